// File: rtl/unmix_pkg.sv
// Shared types and sizing helpers for the nibble un-mixer receive path.
package unmix_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Number of 4-bit beats that carry one A/B word pair of width n.
  function automatic int beats(input int n);
    return n / 2;
  endfunction

  localparam int DEFAULT_N  = 32;
  localparam int DEFAULT_KW = $clog2(DEFAULT_N / 2);

endpackage

// File: rtl/unmix_deser_beat_counter.sv
// Modulo-BEATS beat index with restart-at-one load and clear.
module beat_counter #(
  parameter int BEATS = 16,
  parameter int KW    = $clog2(BEATS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          inc,
  input  logic          load1,
  input  logic          clr,
  output logic [KW-1:0] k,
  output logic          last
);

  logic [KW-1:0] k_r;

  // beat index register; clear wins over restart, restart wins over increment
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k_r <= {KW{1'b0}};
    end else if (clr) begin
      k_r <= {KW{1'b0}};
    end else if (load1) begin
      k_r <= KW'(1);
    end else if (inc) begin
      if (k_r == KW'(BEATS - 1)) begin
        k_r <= {KW{1'b0}};
      end else begin
        k_r <= k_r + KW'(1);
      end
    end
  end

  assign k    = k_r;
  assign last = (k_r == KW'(BEATS - 1));

endmodule

// File: rtl/unmix_deser.sv
// Receive-side nibble un-mixer: reassembles A (LSB-first) and B (MSB-first)
// from 4-bit mixed beats and holds the pair until downstream takes it.
module unmix_deser
  import unmix_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_data,
  input  logic         in_first,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_a,
  output logic [N-1:0] out_b,
  output logic         frame_err
);

  localparam int BEATS = beats(N);
  localparam int KW    = $clog2(BEATS);

  state_t        state_r;
  state_t        state_nxt_s;
  logic          accept_s;
  logic          write_s;
  logic [KW-1:0] widx_s;
  logic          inc_s;
  logic          load1_s;
  logic          clr_s;
  logic          err_s;
  logic          done_s;
  logic [KW-1:0] k_s;
  logic          last_s;
  logic [N-1:0]  out_a_r;
  logic [N-1:0]  out_b_r;
  logic          frame_err_r;

  beat_counter #(
    .BEATS (BEATS),
    .KW    (KW)
  ) u_beat_counter (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (inc_s),
    .load1 (load1_s),
    .clr   (clr_s),
    .k     (k_s),
    .last  (last_s)
  );

  // beat classification: framing checks, write target and counter control
  always_comb begin
    accept_s = in_valid && (state_r == COLLECT);
    write_s  = 1'b0;
    widx_s   = {KW{1'b0}};
    inc_s    = 1'b0;
    load1_s  = 1'b0;
    clr_s    = (state_r == HOLD);
    err_s    = 1'b0;
    done_s   = 1'b0;
    if (accept_s) begin
      if (k_s == {KW{1'b0}}) begin
        if (in_first) begin
          write_s = 1'b1;
          inc_s   = 1'b1;
        end else begin
          err_s = 1'b1;
        end
      end else begin
        if (in_first) begin
          // restart: this beat becomes beat 0, stale bits get overwritten later
          err_s   = 1'b1;
          write_s = 1'b1;
          load1_s = 1'b1;
        end else begin
          write_s = 1'b1;
          widx_s  = k_s;
          inc_s   = 1'b1;
          done_s  = last_s;
        end
      end
    end else begin
      write_s = 1'b0;
    end
  end

  // next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      COLLECT: begin
        if (done_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt_s = COLLECT;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = COLLECT;
    endcase
  end

  // state and framing-error pulse registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= COLLECT;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      frame_err_r <= err_s;
    end
  end

  // direct bit-position writes: beat j owns A[2j+1:2j] and B[N-1-2j:N-2-2j]
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_a_r <= {N{1'b0}};
      out_b_r <= {N{1'b0}};
    end else begin
      for (int j = 0; j < BEATS; j++) begin
        if (write_s && (widx_s == KW'(j))) begin
          out_a_r[2*j]       <= in_data[3];
          out_b_r[N-2-2*j]   <= in_data[2];
          out_a_r[2*j+1]     <= in_data[1];
          out_b_r[N-1-2*j]   <= in_data[0];
        end
      end
    end
  end

  assign in_ready  = (state_r == COLLECT);
  assign out_valid = (state_r == HOLD);
  assign out_a     = out_a_r;
  assign out_b     = out_b_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_unmix_deser.sv
// Self-checking bench for unmix_deser: N=32 against a queue-based frame model,
// plus a directed N=4 instance.
module tb_unmix_deser;

  localparam int N = 32;
  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        v, rdy, f, ov, ordy, fe;
  logic [3:0]  d;
  logic [31:0] oa, ob;
  logic        v4, rdy4, f4, ov4, ordy4, fe4;
  logic [3:0]  d4;
  logic [3:0]  oa4, ob4;

  int checks = 0;
  int errors = 0;

  logic [3:0]  mq[$];
  logic [31:0] ma, mb;
  bit          mhold;

  always #5 clk = ~clk;

  unmix_deser #(.N(32)) dut (
    .clk(clk), .rstn(rstn), .in_valid(v), .in_ready(rdy), .in_data(d),
    .in_first(f), .out_valid(ov), .out_ready(ordy), .out_a(oa), .out_b(ob),
    .frame_err(fe)
  );

  unmix_deser #(.N(4)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
    .in_first(f4), .out_valid(ov4), .out_ready(ordy4), .out_a(oa4), .out_b(ob4),
    .frame_err(fe4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] enc(input logic [31:0] a, input logic [31:0] b, input int k);
    logic [3:0] r;
    r = {a[2*k], b[N-2-2*k], a[2*k+1], b[N-1-2*k]};
    return r;
  endfunction

  // One clock of the N=32 port: predict from the framing rules, drive, check.
  task automatic cyc(input bit iv, input logic [3:0] id, input bit ifst, input bit ordy_i);
    bit acc, err, nhold;
    logic [31:0] ra, rb;
    acc = iv && !mhold;
    err = 1'b0;
    if (acc) begin
      if (ifst) begin
        if (mq.size() != 0) err = 1'b1;
        mq.delete();
        mq.push_back(id);
      end else if (mq.size() == 0) begin
        err = 1'b1;
      end else begin
        mq.push_back(id);
      end
    end
    nhold = mhold ? !ordy_i : 1'b0;
    if (mq.size() == B) begin
      ra = 32'h0;
      rb = 32'h0;
      for (int j = 0; j < B; j++) begin
        ra = ra | (32'(mq[j][3]) << (2*j));
        ra = ra | (32'(mq[j][1]) << (2*j+1));
        rb = rb | (32'(mq[j][2]) << (N-2-2*j));
        rb = rb | (32'(mq[j][0]) << (N-1-2*j));
      end
      ma = ra;
      mb = rb;
      mq.delete();
      nhold = 1'b1;
    end
    v = iv; d = id; f = ifst; ordy = ordy_i;
    @(posedge clk); #1;
    mhold = nhold;
    chk("out_valid", ov, nhold);
    chk("in_ready", rdy, !nhold);
    chk("frame_err", fe, err);
    if (nhold) begin
      chk("out_a", oa, ma);
      chk("out_b", ob, mb);
    end
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input bit ordy_i);
    for (int k = 0; k < B; k++) cyc(1'b1, enc(a, b, k), (k == 0), ordy_i);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rstn = 1'b0;
    v = 1'b0; d = 4'h0; f = 1'b0; ordy = 1'b1;
    v4 = 1'b0; d4 = 4'h0; f4 = 1'b0; ordy4 = 1'b1;
    mhold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ov, 1'b0);
    chk("rst_in_ready", rdy, 1'b1);
    chk("rst_out_a", oa, 32'h0);
    chk("rst_out_b", ob, 32'h0);
    chk("rst_frame_err", fe, 1'b0);
    chk("rst4_out_valid", ov4, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    // missing in_first on the very first beat: flagged and dropped
    cyc(1'b1, 4'h5, 1'b0, 1'b1);
    chk("drop_out_a", oa, 32'h0);
    chk("drop_out_b", ob, 32'h0);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    v = 1'b0;

    // N=4 directed frame A=A, B=6
    v4 = 1'b1; d4 = 4'h6; f4 = 1'b1;
    @(posedge clk); #1;
    chk("n4_valid_b0", ov4, 1'b0);
    chk("n4_err_b0", fe4, 1'b0);
    d4 = 4'h3; f4 = 1'b0;
    @(posedge clk); #1;
    chk("n4_valid", ov4, 1'b1);
    chk("n4_ready", rdy4, 1'b0);
    chk("n4_out_a", oa4, 4'hA);
    chk("n4_out_b", ob4, 4'h6);
    chk("n4_err", fe4, 1'b0);
    v4 = 1'b0;
    @(posedge clk); #1;
    chk("n4_release", ov4, 1'b0);
    chk("n4_ready_back", rdy4, 1'b1);
    chk("n4_kept_a", oa4, 4'hA);
    chk("n4_err_end", fe4, 1'b0);

    // back-to-back frames, out_ready held high
    send_frame(32'h12345678, 32'h9ABCDEF0, 1'b1);
    chk("f1_exact_a", oa, 32'h12345678);
    chk("f1_exact_b", ob, 32'h9ABCDEF0);
    cyc(1'b1, 4'hF, 1'b1, 1'b1);
    send_frame($urandom, $urandom, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);

    // backpressure for 5 cycles, offers ignored
    send_frame($urandom, $urandom, 1'b0);
    repeat (5) cyc(($urandom % 2) == 1, 4'($urandom), ($urandom % 2) == 1, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);

    // mid-frame restart
    ra = $urandom; rb = $urandom;
    cyc(1'b1, enc(ra, rb, 0), 1'b1, 1'b1);
    cyc(1'b1, enc(ra, rb, 1), 1'b0, 1'b1);
    ra = $urandom; rb = $urandom;
    send_frame(ra, rb, 1'b1);
    chk("restart_a", oa, ra);
    chk("restart_b", ob, rb);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);

    // random traffic with occasional framing faults and backpressure
    for (int i = 0; i < 400; i++) begin
      bit fst;
      if (mq.size() == 0) fst = ($urandom % 8) != 0;
      else fst = ($urandom % 12) == 0;
      cyc(($urandom % 4) != 0, 4'($urandom), fst, ($urandom % 2) == 1);
    end
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);

    // async reset in the middle of HOLD, between clock edges
    send_frame($urandom | 32'h1, $urandom | 32'h1, 1'b0);
    v = 1'b0;
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_out_valid", ov, 1'b0);
    chk("arst_out_a", oa, 32'h0);
    chk("arst_out_b", ob, 32'h0);
    chk("arst_in_ready", rdy, 1'b1);
    mq.delete();
    mhold = 1'b0;
    #2;
    rstn = 1'b1;
    @(posedge clk); #1;
    ra = $urandom; rb = $urandom;
    send_frame(ra, rb, 1'b1);
    chk("post_rst_a", oa, ra);
    chk("post_rst_b", ob, rb);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unmix_deser.md
# unmix_deser

Sequential receive-side counterpart of the datapath's nibble bit-mixer. It accepts a stream of 4-bit mixed beats over a valid/ready handshake. It de-interleaves each beat into two N-bit words, A and B, and presents the reassembled pair on a second valid/ready port. It sits between the narrow mixed-nibble link and the N-bit datapath operand registers.

## Interface
- `N`, default 32: word width of A and B; must be even and ≥ 4. The block expects BEATS = N/2 beats per frame.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rstn` input 1: asynchronous active-low reset.
- `in_valid` input 1: `in_data` holds a beat.
- `in_ready` output 1: the block can accept a beat.
- `in_data` input 4: mixed beat.
- `in_first` input 1: marks beat 0 of a frame; qualified by `in_valid`.
- `out_valid` output 1: `out_a` and `out_b` hold a complete frame.
- `out_ready` input 1: downstream accepts the frame.
- `out_a` output N: reassembled A.
- `out_b` output N: reassembled B.
- `frame_err` output 1: one-cycle pulse on a framing violation.

## Operation
- Clock and reset: one clock, `clk`. Reset `rstn` is asynchronous and active-low.
- Beat mapping: beat k carries 2 bits of A LSB-first and 2 bits of B MSB-first.
  - `in_data[3]` = A[2k]
  - `in_data[2]` = B[N-2-2k]
  - `in_data[1]` = A[2k+1]
  - `in_data[0]` = B[N-1-2k]
  - For k = 0 with N = 4 this is {A[0], B[2], A[1], B[3]}.
- Accept: a beat is accepted when `in_valid` and `in_ready` are both high in the same cycle. An accepted beat writes its four bits directly into bit positions of the `out_a`/`out_b` registers. There is no shift.
- States:
  - COLLECT: `in_ready` = 1, `out_valid` = 0.
  - HOLD: `in_ready` = 0, `out_valid` = 1.
  - `in_ready` and `out_valid` are decoded from the state register only. There is no combinational path from input to output.
- Beat counter k, width $clog2(BEATS):
  - It increments on each accepted, in-frame beat.
  - When beat BEATS-1 is accepted, k returns to 0 and the state goes COLLECT → HOLD.
- Leaving HOLD: when `out_valid` and `out_ready` are both high, the state goes HOLD → COLLECT. `out_a`/`out_b` keep their values; they are not cleared.
- Framing rules:
  - `in_first` = 1 on an accepted beat with k ≠ 0: pulse `frame_err`. Discard the partial frame by overwrite, treat this beat as beat 0, and set k to 1.
  - `in_first` = 0 on an accepted beat with k = 0: pulse `frame_err`, drop the beat, k stays 0, and no bits are written.
  - `in_first` = 1 with k = 0: normal frame start, no error.
- Reset values: state COLLECT, k = 0, `out_a` = 0, `out_b` = 0, `out_valid` = 0, `frame_err` = 0, `in_ready` = 1.
- Reset mid-frame or mid-HOLD: the partial or held frame is lost. No `out_valid` is produced for it.

## Timing
- Accept rate: one beat per cycle while in COLLECT.
- Output latency: `out_valid` rises in the cycle after the last beat is accepted.
- Minimum frame period: BEATS + 1 cycles when `out_ready` is held high. This is 17 cycles for N = 32.
- HOLD backpressure: `in_ready` stays 0 for the whole of HOLD. `out_a`/`out_b` are stable while `out_valid` = 1.
- `frame_err`: registered, high for exactly one cycle, the cycle after the offending beat is accepted.
- Beats offered while `in_ready` = 0 are neither accepted nor flagged.

## Structure
- Package `unmix_pkg`:
  - `state_t` enum {COLLECT, HOLD}.
  - Function `beats(N)` returning N/2.
  - Localparam for the counter width.
- One sub-module, `beat_counter`:
  - Parameterised modulo-BEATS counter.
  - Inputs: `inc`, `load1`, `clr`.
  - Outputs: `k` and `last` (k == BEATS-1).
- The top level holds the FSM, bit-position write enables and the `frame_err` register.

## Test plan
- N = 4, A = 4'hA, B = 4'h6:
  - Send beat 0x6 with `in_first` = 1, then beat 0x3.
  - Required: `out_valid` rises 1 cycle after the second beat, with `out_a` = 4'hA, `out_b` = 4'h6, and `frame_err` never pulses.
- N = 32, A = 32'h12345678, B = 32'h9ABCDEF0, 16 beats back-to-back, `out_ready` = 1:
  - Required: the words match exactly.
  - Required: a second frame is accepted starting cycle 17, and `in_ready` is 0 only in the HOLD cycle.
- Backpressure: hold `out_ready` = 0 for 5 cycles after a frame completes.
  - Required: `in_ready` stays 0 and the outputs stay stable.
  - Required: the frame is released on the cycle `out_ready` = 1, then COLLECT resumes.
- Mid-frame `in_first` (N = 8): send 2 beats, then a beat with `in_first` = 1.
  - Required: `frame_err` pulses once, and the next 3 beats complete a frame built from the restart beat onward.
- Missing `in_first`: first beat after reset has `in_first` = 0.
  - Required: `frame_err` pulses, the beat is dropped, and `out_a`/`out_b` remain 0.
- Asynchronous reset asserted mid-HOLD, between clock edges.
  - Required: `out_valid`, `out_a` and `out_b` go to 0 immediately, `in_ready` = 1, and a fresh frame after release decodes correctly.
